// File: rtl/seq_magnitude_comparator_pkg.sv
// cmp_pkg: shared types and constants for seq_magnitude_comparator.
//   state_t   - control FSM states (IDLE, CMP, DONE)
//   RES_*     - one-hot {gt, eq, lt} result encodings
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: operand/result handshake bundle.
//   in_valid/in_ready        - operand handshake (in1, in2, signed_mode)
//   out_valid/out_ready      - result handshake (gt, eq, lt)
//   busy                     - comparator is stepping through chunks
// master: operand producer / result consumer.  slave: the comparator.
// WIDTH must match the comparator's WIDTH parameter.
interface seq_magnitude_comparator_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             busy;

    modport master (
        output in_valid, in1, in2, signed_mode, out_ready,
        input  in_ready, out_valid, gt, eq, lt, busy
    );

    modport slave (
        input  in_valid, in1, in2, signed_mode, out_ready,
        output in_ready, out_valid, gt, eq, lt, busy
    );
endinterface

// File: rtl/seq_magnitude_comparator_chunk_cmp.sv
// chunk_cmp: combinational unsigned compare of one CHUNK-bit slice.
//   a, b      - slices of operand A and B
//   chunk_gt  - a > b
//   chunk_lt  - a < b
module chunk_cmp #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             chunk_gt,
    output logic             chunk_lt
);
    assign chunk_gt = (a > b);
    assign chunk_lt = (a < b);
endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first magnitude comparator.
// Compares two WIDTH-bit operands CHUNK bits per clock, unsigned or
// two's-complement, and reports one-hot gt/eq/lt behind valid/ready.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - seq_magnitude_comparator_if.slave (operand and result handshakes)
// Build option: COMPARE_EARLY_EXIT_EN - finish as soon as a chunk differs.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input logic                      clk,
    input logic                      rst,
    seq_magnitude_comparator_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    // Elaboration-time parameter checks
    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "seq_magnitude_comparator: WIDTH must be >= 2");
    end
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $fatal(1, "seq_magnitude_comparator: CHUNK must divide WIDTH");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] opa, opa_n;
    logic [WIDTH-1:0] opb, opb_n;
    logic [IDXW-1:0]  idx, idx_n;
    logic [2:0]       res, res_n;
    logic             decided, decided_n;
    logic             load;

    logic [CHUNK-1:0] slice_a, slice_b;
    logic             cgt, clt;

    // Current chunk under comparison
    assign slice_a = opa[idx*CHUNK +: CHUNK];
    assign slice_b = opb[idx*CHUNK +: CHUNK];

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a        (slice_a),
        .b        (slice_b),
        .chunk_gt (cgt),
        .chunk_lt (clt)
    );

    // Handshake and status decode; in_ready is held low throughout reset
    assign bus.in_ready  = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == CMP);
    assign bus.gt        = res[2];
    assign bus.eq        = res[1];
    assign bus.lt        = res[0];

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        opa_n     = opa;
        opb_n     = opb;
        idx_n     = idx;
        res_n     = res;
        decided_n = decided;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.in_valid) load = 1'b1;
            end
            CMP: begin
                // First differing chunk from the top decides; lower ones are ignored
                if (!decided && (cgt || clt)) begin
                    res_n     = cgt ? RES_GT : RES_LT;
                    decided_n = 1'b1;
`ifdef COMPARE_EARLY_EXIT_EN
                    state_n   = DONE;
`endif
                end
                if (idx == '0) begin
                    if (!decided && !(cgt || clt)) res_n = RES_EQ;
                    state_n = DONE;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) load = 1'b1;
                    else              state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Flipping the MSB maps two's-complement onto offset binary so the
        // unsigned chunk compare gives the signed ordering.
        if (load) begin
            opa_n     = bus.in1 ^ (bus.signed_mode ? MSB_MASK : '0);
            opb_n     = bus.in2 ^ (bus.signed_mode ? MSB_MASK : '0);
            idx_n     = LAST_IDX;
            res_n     = RES_NONE;
            decided_n = 1'b0;
            state_n   = CMP;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            opa     <= '0;
            opb     <= '0;
            idx     <= LAST_IDX;
            res     <= RES_NONE;
            decided <= 1'b0;
        end else begin
            state   <= state_n;
            opa     <= opa_n;
            opb     <= opb_n;
            idx     <= idx_n;
            res     <= res_n;
            decided <= decided_n;
        end
    end
endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator: next generation of the team's 2-bit comparator. Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, in unsigned or two's-complement mode. Reports one-hot gt/eq/lt behind a valid/ready handshake on both sides. Sits between operand-producing datapath stages and control logic that consumes ordering decisions.

## Interface
- WIDTH, 8, operand width; ≥2.
- CHUNK, 2, bits compared per cycle; must divide WIDTH; NCHUNK = WIDTH/CHUNK.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept operands.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- gt / eq / lt  output  1 each  in1 > / = / < in2; one-hot while out_valid.
- busy  output  1  high in CMP state.

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE: in_ready=1. On in_valid: capture in1/in2; if signed_mode, invert MSB of both (offset-binary mapping); clear gt/eq/lt and decided flag; chunk index := NCHUNK-1; go CMP.
- CMP: compare chunk[index] of both operands. If not yet decided and chunks differ: set gt or lt, set decided. Later, lower chunks are ignored once decided. After processing index 0: if undecided set eq; go DONE. Otherwise decrement index.
- DONE: out_valid=1, gt/eq/lt held stable until out_ready. On out_ready: if in_valid in same cycle, capture new operands and go CMP (in_ready = out_ready in DONE); else go IDLE.
- in_ready=0 in CMP. Operand changes during CMP have no effect.
- Reset (any time, including mid-CMP): state IDLE, out_valid/gt/eq/lt/busy = 0, index = NCHUNK-1. in_ready is forced 0 while rst is high.

## Timing
- Acceptance edge = rising edge where in_valid && in_ready.
- Latency: out_valid rises NCHUNK edges after the acceptance edge (early exit off).
- Throughput with out_ready tied high: one result per NCHUNK+1 cycles, no idle bubble.
- out_valid stays high and results stay stable until the edge where out_ready=1. There is no combinational path from in_* to out_*.

## Configuration
- COMPARE_EARLY_EXIT_EN defined: CMP goes to DONE on the edge that sets decided. Latency is NCHUNK-k, where k is the index of the highest differing chunk. Equal operands still take NCHUNK cycles.
- Undefined: fixed NCHUNK-cycle latency for all operands.

## Structure
- Package cmp_pkg: FSM state enum (IDLE, CMP, DONE), result encoding constants (RES_GT, RES_EQ, RES_LT).
- Elaboration-time checks on WIDTH ≥ 2 and WIDTH % CHUNK == 0, with a fatal error on violation.
- One sub-module: chunk_cmp, a combinational CHUNK-bit comparator producing chunk_gt/chunk_lt. It is instantiated once and fed by an index-selected slice.

## Test plan
All scenarios use WIDTH=8, CHUNK=2.
- Unsigned 0xA5 vs 0x5A, out_ready=1 → gt=1, eq=lt=0. out_valid 4 cycles after acceptance (1 cycle with early exit).
- 0xFF vs 0xFF, both modes → eq=1 after 4 cycles in both configurations.
- 0x80 vs 0x7F: signed_mode=1 → lt=1; signed_mode=0 → gt=1.
- 0x40 vs 0x41 (differ in LSB chunk only) → lt=1, latency 4 in both configurations.
- Backpressure: out_ready=0 for 5 cycles after result → out_valid, gt/eq/lt and in_ready=0 held unchanged. Then out_ready=in_valid=1 in the same cycle with 0x03 vs 0x03 → accepted immediately, eq=1 after 4 cycles.
- rst pulsed during 2nd CMP cycle → all outputs 0 immediately, state IDLE. After release, 0x01 vs 0x02 → lt=1 after 4 cycles.
